// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog reset generator: channel state encoding and
// a width helper for the pulse timer.
package wdt_pkg;

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  typedef enum logic [1:0] {
    StArm  = ST_ARM,
    StFire = ST_FIRE,
    StLock = ST_LOCK
  } wdt_state_e;

  // Smallest r with 2**r >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wdt_reset_gen_if.sv
// Control/status bundle of the watchdog reset generator: enables, fail inputs,
// limits and clear in; per-channel resets, merged reset and cause mask out.
interface wdt_reset_gen_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       wdfail;
  logic [CHANNELS*WIDTH-1:0] rst_lmt;
  logic                      clr;
  logic [CHANNELS-1:0]       ch_rst;
  logic                      rstout;
  logic [CHANNELS-1:0]       cause;

  modport master (
    output en, wdfail, rst_lmt, clr,
    input  ch_rst, rstout, cause
  );

  modport slave (
    input  en, wdfail, rst_lmt, clr,
    output ch_rst, rstout, cause
  );
endinterface

// File: rtl/wdt_channel.sv
// One watchdog channel: counts consecutive fail cycles, fires a fixed-width reset
// pulse when the live limit is reached, then optionally locks until cleared.
module wdt_channel
  import wdt_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PULSE_W = 8,
  parameter int unsigned STICKY  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wdfail,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr,
  output logic             ch_rst,
  output logic             ch_rst_nxt,
  output logic             fire
);

  localparam int unsigned PW = clog2(PULSE_W + 1);

  wdt_state_e     state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    p_q, p_d;
  logic             ch_rst_q, ch_rst_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StArm;
      q_q      <= '0;
      p_q      <= '0;
      ch_rst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      p_q      <= p_d;
      ch_rst_q <= ch_rst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    p_d      = p_q;
    ch_rst_d = ch_rst_q;
    fire     = 1'b0;
    if (!en) begin
      state_d  = StArm;
      q_d      = '0;
      p_d      = '0;
      ch_rst_d = 1'b0;
    end else begin
      unique case (state_q)
        StArm: begin
          ch_rst_d = 1'b0;
          if (!wdfail) begin
            q_d = '0;
          end else if (q_q >= limit) begin
            state_d  = StFire;
            ch_rst_d = 1'b1;
            p_d      = PW'(PULSE_W - 1);
            fire     = 1'b1;
          end else if (q_q != {WIDTH{1'b1}}) begin
            q_d = q_q + WIDTH'(1);
          end
        end
        StFire: begin
          // The pulse width is fixed; wdfail only decides where we land afterwards.
          if (p_q == '0) begin
            ch_rst_d = 1'b0;
            q_d      = '0;
            state_d  = ((STICKY != 0) || wdfail) ? StLock : StArm;
          end else begin
            p_d = p_q - PW'(1);
          end
        end
        StLock: begin
          ch_rst_d = 1'b0;
          q_d      = '0;
          if (clr || ((STICKY == 0) && !wdfail)) state_d = StArm;
        end
        default: begin
          state_d  = StArm;
          q_d      = '0;
          ch_rst_d = 1'b0;
        end
      endcase
    end
  end

  assign ch_rst     = ch_rst_q;
  assign ch_rst_nxt = ch_rst_d;

endmodule

// File: rtl/wdt_reset_gen.sv
// Multi-channel watchdog reset generator: per-channel fail counters with a merged
// registered reset output and a sticky cause mask for the reset controller.
module wdt_reset_gen
  import wdt_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PULSE_W  = 8,
  parameter int unsigned STICKY   = 0
) (
  input logic            clk,
  input logic            rst,
  wdt_reset_gen_if.slave bus
);

  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] ch_rst;
  logic [CHANNELS-1:0] ch_rst_nxt;
  logic [CHANNELS-1:0] cause_q, cause_d;
  logic                rstout_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    wdt_channel #(
      .WIDTH  (WIDTH),
      .PULSE_W(PULSE_W),
      .STICKY (STICKY)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en[i]),
      .wdfail    (bus.wdfail[i]),
      .limit     (bus.rst_lmt[i*WIDTH +: WIDTH]),
      .clr       (bus.clr),
      .ch_rst    (ch_rst[i]),
      .ch_rst_nxt(ch_rst_nxt[i]),
      .fire      (fire[i])
    );
  end

  // A fire in the same cycle as a clear still records its cause.
  always_comb begin
    cause_d = (bus.clr ? '0 : cause_q) | fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q  <= '0;
      rstout_q <= 1'b0;
    end else begin
      cause_q  <= cause_d;
      rstout_q <= |ch_rst_nxt;
    end
  end

  assign bus.ch_rst = ch_rst;
  assign bus.rstout = rstout_q;
  assign bus.cause  = cause_q;

endmodule

// File: tb/tb_wdt_reset_gen.sv
// Bench for wdt_reset_gen: directed vector table, hand sequences for lock and
// async reset, and a randomized run against a cycle-level reference model.
module tb_wdt_reset_gen;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wdt_reset_gen_if #(.CHANNELS(CH), .WIDTH(W)) bus_n ();
  wdt_reset_gen_if #(.CHANNELS(CH), .WIDTH(W)) bus_s ();

  wdt_reset_gen #(.CHANNELS(CH), .WIDTH(W), .PULSE_W(PW), .STICKY(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );
  wdt_reset_gen #(.CHANNELS(CH), .WIDTH(W), .PULSE_W(PW), .STICKY(1)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  typedef struct {
    int          id;
    int          n;
    logic [3:0]  en;
    logic [3:0]  wdfail;
    logic [63:0] lmt;
    logic        clr;
    logic [3:0]  exp_rst;
    logic [3:0]  exp_cause;
  } vec_t;

  int passed = 0;
  int total  = 0;

  logic [3:0]  en_v, wd_v;
  logic [63:0] lmt_v;
  logic        clr_v;

  int         m_cnt[2][4];
  int         m_rem[2][4];
  bit         m_lock[2][4];
  logic [3:0] m_cause[2];

  function automatic logic [63:0] lm(int a, int b, int c, int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic chk(int id, string name, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL t%0d %s: got %b expected %b (time %0t)", id, name, act, exp, $time);
  endtask

  task automatic cmp_dut(int d, int id, logic [3:0] er, logic [3:0] ec);
    logic [3:0] a_rst, a_cause;
    logic       a_out;
    if (d == 0) begin
      a_rst = bus_n.ch_rst; a_out = bus_n.rstout; a_cause = bus_n.cause;
    end else begin
      a_rst = bus_s.ch_rst; a_out = bus_s.rstout; a_cause = bus_s.cause;
    end
    chk(id, d == 0 ? "ch_rst" : "ch_rst_sticky", a_rst, er);
    chk(id, d == 0 ? "rstout" : "rstout_sticky", {3'b0, a_out}, {3'b0, |er});
    chk(id, d == 0 ? "cause" : "cause_sticky", a_cause, ec);
  endtask

  task automatic drive();
    bus_n.en = en_v; bus_n.wdfail = wd_v; bus_n.rst_lmt = lmt_v; bus_n.clr = clr_v;
    bus_s.en = en_v; bus_s.wdfail = wd_v; bus_s.rst_lmt = lmt_v; bus_s.clr = clr_v;
  endtask

  task automatic run_vec(vec_t v, int d);
    for (int k = 0; k < v.n; k++) begin
      en_v = v.en; wd_v = v.wdfail; lmt_v = v.lmt; clr_v = v.clr;
      drive();
      @(posedge clk);
      #1;
      cmp_dut(d, v.id, v.exp_rst, v.exp_cause);
    end
  endtask

  task automatic do_reset();
    en_v = 4'hF; wd_v = '0; lmt_v = lm(100, 100, 100, 100); clr_v = 1'b0;
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cause[d] = '0;
      for (int c = 0; c < 4; c++) begin
        m_cnt[d][c] = 0; m_rem[d][c] = 0; m_lock[d][c] = 0;
      end
    end
  endtask

  // One clock edge of the channel rules: count fails, pulse for PW cycles, lock or re-arm.
  task automatic model_step(int d, bit sticky);
    logic [3:0] fired;
    fired = '0;
    for (int c = 0; c < 4; c++) begin
      if (!en_v[c]) begin
        m_cnt[d][c] = 0; m_rem[d][c] = 0; m_lock[d][c] = 0;
      end else if (m_rem[d][c] > 0) begin
        m_rem[d][c]--;
        if (m_rem[d][c] == 0) begin
          m_cnt[d][c]  = 0;
          m_lock[d][c] = sticky || wd_v[c];
        end
      end else if (m_lock[d][c]) begin
        if (clr_v || (!sticky && !wd_v[c])) m_lock[d][c] = 0;
      end else if (!wd_v[c]) begin
        m_cnt[d][c] = 0;
      end else if (m_cnt[d][c] >= int'(lmt_v[c*16 +: 16])) begin
        m_rem[d][c] = PW;
        fired[c]    = 1'b1;
      end else if (m_cnt[d][c] < 65535) begin
        m_cnt[d][c]++;
      end
    end
    m_cause[d] = (clr_v ? 4'b0 : m_cause[d]) | fired;
  endtask

  function automatic logic [3:0] model_rst(int d);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (m_rem[d][c] > 0);
    return r;
  endfunction

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    logic [63:0] l1, l2, l3, l6a, l6b, l4, l5;
    l1  = lm(5, 100, 100, 100);
    l2  = lm(100, 4, 100, 100);
    l3  = lm(100, 100, 0, 0);
    l6a = lm(100, 20, 100, 100);
    l6b = lm(100, 7, 100, 100);
    l4  = lm(2, 100, 100, 100);
    l5  = lm(3, 100, 100, 100);

    // id, n, en, wdfail, limits, clr, expected ch_rst, expected cause
    tbl.push_back('{1, 5, 4'hF, 4'h1, l1, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{1, 8, 4'hF, 4'h1, l1, 1'b0, 4'h1, 4'h1});
    tbl.push_back('{1, 1, 4'hF, 4'h1, l1, 1'b0, 4'h0, 4'h1});
    tbl.push_back('{1, 2, 4'hF, 4'h0, l1, 1'b0, 4'h0, 4'h1});
    tbl.push_back('{1, 1, 4'hF, 4'h0, l1, 1'b1, 4'h0, 4'h0});
    tbl.push_back('{2, 3, 4'hF, 4'h2, l2, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{2, 1, 4'hF, 4'h0, l2, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{2, 3, 4'hF, 4'h2, l2, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{2, 1, 4'hF, 4'h0, l2, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{3, 8, 4'hF, 4'hC, l3, 1'b0, 4'hC, 4'hC});
    tbl.push_back('{3, 1, 4'hF, 4'hC, l3, 1'b0, 4'h0, 4'hC});
    tbl.push_back('{3, 1, 4'hF, 4'h0, l3, 1'b0, 4'h0, 4'hC});
    tbl.push_back('{3, 1, 4'hF, 4'h0, l3, 1'b1, 4'h0, 4'h0});
    tbl.push_back('{6, 10, 4'hF, 4'h2, l6a, 1'b0, 4'h0, 4'h0});
    tbl.push_back('{6, 1, 4'hF, 4'h2, l6b, 1'b0, 4'h2, 4'h2});
    tbl.push_back('{6, 2, 4'hF, 4'h2, l6b, 1'b0, 4'h2, 4'h2});
    tbl.push_back('{6, 1, 4'hD, 4'h2, l6b, 1'b0, 4'h0, 4'h2});
    tbl.push_back('{6, 1, 4'hF, 4'h0, l6b, 1'b1, 4'h0, 4'h0});

    // Sticky lock: no re-fire until clear, then a fresh count of limit+1 fails.
    seq.push_back('{4, 2, 4'hF, 4'h1, l4, 1'b0, 4'h0, 4'h0});
    seq.push_back('{4, 1, 4'hF, 4'h1, l4, 1'b0, 4'h1, 4'h1});
    seq.push_back('{4, 7, 4'hF, 4'h0, l4, 1'b0, 4'h1, 4'h1});
    seq.push_back('{4, 1, 4'hF, 4'h0, l4, 1'b0, 4'h0, 4'h1});
    seq.push_back('{4, 10, 4'hF, 4'h1, l4, 1'b0, 4'h0, 4'h1});
    seq.push_back('{4, 1, 4'hF, 4'h1, l4, 1'b1, 4'h0, 4'h0});
    seq.push_back('{4, 2, 4'hF, 4'h1, l4, 1'b0, 4'h0, 4'h0});
    seq.push_back('{4, 1, 4'hF, 4'h1, l4, 1'b0, 4'h1, 4'h1});

    do_reset();
    cmp_dut(0, 0, 4'h0, 4'h0);
    cmp_dut(1, 0, 4'h0, 4'h0);

    foreach (tbl[i]) run_vec(tbl[i], 0);

    do_reset();
    foreach (seq[i]) run_vec(seq[i], 1);

    // Asynchronous reset in the third pulse cycle clears outputs before any edge.
    do_reset();
    run_vec('{5, 3, 4'hF, 4'h1, l5, 1'b0, 4'h0, 4'h0}, 0);
    run_vec('{5, 1, 4'hF, 4'h1, l5, 1'b0, 4'h1, 4'h1}, 0);
    run_vec('{5, 2, 4'hF, 4'h1, l5, 1'b0, 4'h1, 4'h1}, 0);
    #3;
    rst = 1'b1;
    #1;
    cmp_dut(0, 5, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec('{5, 3, 4'hF, 4'h1, l5, 1'b0, 4'h0, 4'h0}, 0);
    run_vec('{5, 1, 4'hF, 4'h1, l5, 1'b0, 4'h1, 4'h1}, 0);

    do_reset();
    model_reset();
    lmt_v = lm(3, 1, 0, 5);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        en_v[c] = ($urandom_range(0, 19) != 0);
        wd_v[c] = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 9) == 0) lmt_v[c*16 +: 16] = 16'($urandom_range(0, 6));
      end
      clr_v = ($urandom_range(0, 15) == 0);
      drive();
      @(posedge clk);
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      #1;
      cmp_dut(0, 7, model_rst(0), m_cause[0]);
      cmp_dut(1, 7, model_rst(1), m_cause[1]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wdt_reset_gen.md
Name: wdt_reset_gen

Overview:
Multi-channel watchdog reset generator, the parametrised successor to the single-channel fail counter. Each channel counts consecutive cycles with its WDFAIL input high. When the count reaches that channel's limit, the channel issues a reset pulse of programmable width. A global RSTOUT (OR of all channels) and a latched cause mask feed the system reset controller and its status register.

Parameters:
CHANNELS, 4, number of independent watchdog channels (1..16)
WIDTH, 16, counter and limit width in bits
PULSE_W, 8, reset pulse length in CLK cycles (>=1)
STICKY, 0, 1 = channel stays locked after firing until CLR; 0 = re-arms when its WDFAIL goes low

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
EN  input  CHANNELS  per-channel enable; 0 forces the channel idle
WDFAIL  input  CHANNELS  per-channel fail indication, 1 = fail condition present
RST_LMT  input  CHANNELS*WIDTH  per-channel limit, channel i at bits [i*WIDTH +: WIDTH]
CLR  input  1  single-cycle clear: clears CAUSE and releases locked channels
CH_RST  output  CHANNELS  per-channel reset pulse, registered
RSTOUT  output  1  registered OR of the next-cycle CH_RST values, aligned with CH_RST
CAUSE  output  CHANNELS  sticky mask of channels that have fired since the last CLR/RST

Behaviour:
- Clocking and reset: one clock, CLK; reset is asynchronous and active-high on RST. While RST is high, all counters, CH_RST, RSTOUT and CAUSE are 0 and every channel is in ARM. Release is synchronous to the next CLK edge.
- Per-channel state machine, states ARM, FIRE, LOCK; counter q[WIDTH] and pulse counter p[clog2(PULSE_W+1)].
- ARM:
  - WDFAIL=0 → q<=0.
  - WDFAIL=1 and q>=limit → go to FIRE, CH_RST<=1, p<=PULSE_W-1, set CAUSE[i].
  - WDFAIL=1 otherwise → q<=q+1, saturating at all-ones.
- Latency: with WDFAIL held high from edge 0 and limit L, CH_RST rises after edge L (L+1 sampled fail cycles). Limit 0 fires on the first sampled fail cycle.
- The comparison is >=, evaluated live against RST_LMT each cycle. Lowering the limit below the current q fires on the next fail cycle. Raising it extends the count.
- FIRE:
  - CH_RST stays high for exactly PULSE_W cycles, independent of WDFAIL.
  - When p==0 → CH_RST<=0 and q<=0.
  - Next state: LOCK if STICKY=1 or WDFAIL=1; else ARM.
- LOCK:
  - CH_RST=0 and the counter is held at 0.
  - STICKY=0: exit to ARM on the first cycle WDFAIL=0.
  - STICKY=1: exit to ARM only on CLR=1.
- EN=0 in any state: next edge → ARM, q<=0, CH_RST<=0. The pulse is truncated. CAUSE is unaffected.
- CLR:
  - Clears all CAUSE bits and moves LOCK channels to ARM.
  - Has no effect on channels in ARM counting or in FIRE.
  - If a channel fires in the same cycle as CLR, the set wins: CAUSE[i]=1.
- Simultaneous fires: every channel firing in a cycle sets its CAUSE bit. RSTOUT stays high while any CH_RST is high. Overlapping pulses merge on RSTOUT with no gap.
- RSTOUT is registered and asserts on the same edge as the corresponding CH_RST.

Decomposition:
- Shared package wdt_pkg: state encoding localparams (ST_ARM=2'd0, ST_FIRE=2'd1, ST_LOCK=2'd2) and a clog2 function for the pulse counter width.
- Sub-module wdt_channel: one channel's FSM, counter and pulse timer, parametrised by WIDTH/PULSE_W/STICKY. It outputs ch_rst and a fire strobe.
- The top level instantiates CHANNELS copies via generate and owns CAUSE and the RSTOUT register.

Test Plan:
1. CHANNELS=4, limit ch0=5, WDFAIL[0] high continuously → CH_RST[0] rises after the 6th sampled fail edge, stays high 8 cycles; RSTOUT identical; CAUSE=4'b0001.
2. WDFAIL[1] high 3 cycles, low 1, high 3 cycles, limit 4 → no fire, q returns to 0 on the low cycle; CAUSE stays 0.
3. Limit 0 on ch2 and ch3, both WDFAIL rise on the same edge → both CH_RST rise after that edge; CAUSE=4'b1100; RSTOUT high 8 cycles.
4. STICKY=1, ch0 fires, WDFAIL[0] dropped → channel stays in LOCK, no re-fire when WDFAIL returns; CLR pulse → CAUSE=0, ch0 fires again after limit+1 fail cycles.
5. RST asserted mid-pulse (cycle 3 of 8) asynchronously → CH_RST, RSTOUT and CAUSE go to 0 immediately, before the next edge; after release a fresh count is required.
6. Ch1 counting at q=10 with limit 20, limit changed to 7 → fire on the next fail cycle; separately, EN[1]=0 during FIRE truncates the pulse on the next edge.
